// File: rtl/mv_serializer.sv
// ----------------------------------------------------------------------------
// mv_serializer
//
// Purpose:
//   Serialises one DATA_WIDTH-bit word LSB first onto a single line. Each bit
//   is held for REPEAT sample ticks. The word is followed by GAP ticks of
//   forced-low line. A sample tick is a clock cycle with sample_i high.
//   Words are accepted with a valid/ready handshake. The next word can be
//   accepted in the same cycle that done_o reports completion of the
//   previous word.
//
// Optional feature (compile-time macro MV_SERIALIZER_PARITY_EN):
//   When the macro is defined, an even-parity bit (XOR of the word) is sent
//   after the data bits. It is held for REPEAT ticks before the gap. In the
//   default build the parity state and parity logic are absent.
//
// Parameters:
//   DATA_WIDTH - bits per word (>= 1)
//   REPEAT     - sample ticks each bit is held on the line (>= 1)
//   GAP        - sample ticks of low line after each word (>= 1)
//
// Ports:
//   clk_i    in   clock, all state on the rising edge
//   rst_i    in   asynchronous active-high reset
//   clr_i    in   synchronous clear, same effect as reset, dominates everything
//   sample_i in   tick strobe advancing the hold counters
//   valid_i  in   word offered
//   ready_o  out  high in IDLE unless clr_i; word accepted on valid_i && ready_o
//   data_i   in   word to send
//   q_o      out  registered serial line
//   busy_o   out  high whenever the FSM is not in IDLE
//   done_o   out  one-cycle pulse when the gap after a word has completed
// ----------------------------------------------------------------------------
module mv_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int REPEAT     = 10,
    parameter int GAP        = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  sample_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  q_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int TICK_W = $clog2(REPEAT + 1);
    localparam int GAP_W  = $clog2(GAP + 1);
    localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // The counters clear on the tick that would reach the limit. They
    // therefore compare against limit-1 and never hold the limit itself.
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REPEAT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("mv_serializer: DATA_WIDTH must be >= 1");
    end
    if (REPEAT < 1) begin : g_bad_repeat
        $error("mv_serializer: REPEAT must be >= 1");
    end
    if (GAP < 1) begin : g_bad_gap
        $error("mv_serializer: GAP must be >= 1");
    end

`ifdef MV_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_GAP    = 2'd2,
        S_PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_GAP    = 2'd2
    } state_t;
`endif

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic                  r_q;
    logic                  r_done;
`ifdef MV_SERIALIZER_PARITY_EN
    logic                  r_parity;
`endif

    logic                  w_handshake;
    logic                  w_bit_end;
    logic                  w_gap_end;
    logic [DATA_WIDTH-1:0] w_shifted;

    // NOTE: ready_o depends on state and clr_i only. It never depends on
    // valid_i, so a source that waits for ready before raising valid cannot
    // form a combinational loop through this block.
    assign ready_o     = (r_state == S_IDLE) && !clr_i;
    assign w_handshake = valid_i && ready_o;
    assign w_bit_end   = sample_i && (r_tick_cnt == TICK_LAST);
    assign w_gap_end   = sample_i && (r_gap_cnt == GAP_LAST);
    assign w_shifted   = r_shreg >> 1;

    assign q_o    = r_q;
    assign busy_o = (r_state != S_IDLE);
    assign done_o = r_done;

    // NOTE: every register here, including the shift register, is assigned
    // with <= and cleared by both reset and clear. This keeps an aborted word
    // from leaving stale data behind.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_tick_cnt <= '0;
            r_gap_cnt  <= '0;
            r_bit_idx  <= '0;
            r_q        <= 1'b0;
            r_done     <= 1'b0;
`ifdef MV_SERIALIZER_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else if (clr_i) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_tick_cnt <= '0;
            r_gap_cnt  <= '0;
            r_bit_idx  <= '0;
            r_q        <= 1'b0;
            r_done     <= 1'b0;
`ifdef MV_SERIALIZER_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Ticks are ignored while idle. Bit 0 is driven
                    // directly from data_i so it appears on the line in the
                    // cycle after the handshake.
                    if (w_handshake) begin
                        r_shreg    <= data_i;
                        r_q        <= data_i[0];
                        r_tick_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= S_DATA;
`ifdef MV_SERIALIZER_PARITY_EN
                        r_parity   <= ^data_i;
`endif
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_tick_cnt <= '0;
                        r_shreg    <= w_shifted;
                        if (r_bit_idx == IDX_LAST) begin
                            r_bit_idx <= '0;
`ifdef MV_SERIALIZER_PARITY_EN
                            r_q       <= r_parity;
                            r_state   <= S_PARITY;
`else
                            r_q       <= 1'b0;
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_q       <= w_shifted[0];
                        end
                    end else if (sample_i) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end

`ifdef MV_SERIALIZER_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_tick_cnt <= '0;
                        r_q        <= 1'b0;
                        r_gap_cnt  <= '0;
                        r_state    <= S_GAP;
                    end else if (sample_i) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
`endif

                S_GAP: begin
                    if (w_gap_end) begin
                        r_gap_cnt <= '0;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (sample_i) begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                default: begin
                    r_q     <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mv_serializer.sv
// ----------------------------------------------------------------------------
// tb_mv_serializer
//
// Self-checking bench for mv_serializer with default parameters. The
// reference model describes the line as a function of the number of sample
// ticks seen since the handshake: bit (t / REPEAT) while t < NBITS*REPEAT,
// then low for GAP ticks, then done. Defining MV_SERIALIZER_PARITY_EN for the
// whole compile also enables the parity expectations.
// ----------------------------------------------------------------------------
module tb_mv_serializer;

    localparam int DW  = 8;
    localparam int REP = 10;
    localparam int GP  = 4;
`ifdef MV_SERIALIZER_PARITY_EN
    localparam int NBITS   = DW + 1;
    localparam int EXP_LAT = 95;
`else
    localparam int NBITS   = DW;
    localparam int EXP_LAT = 85;
`endif
    localparam int WORD_TICKS = NBITS * REP + GP;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          clr    = 1'b0;
    logic          sample = 1'b0;
    logic          valid  = 1'b0;
    logic [DW-1:0] data   = '0;
    logic          ready;
    logic          q;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fails  = 0;

    // Shared between the stream engine and the scenario tasks.
    logic [DW-1:0] tx_q[$];
    logic          q_log[$];
    int            obs_hs[$];
    int            obs_done[$];

    mv_serializer #(
        .DATA_WIDTH (DW),
        .REPEAT     (REP),
        .GAP        (GP)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (clr),
        .sample_i (sample),
        .valid_i  (valid),
        .ready_o  (ready),
        .data_i   (data),
        .q_o      (q),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line level after t ticks of the current word.
    function automatic logic line_bit(input logic [DW-1:0] w, input int t);
        int b;
        b = t / REP;
        if (b < DW) return w[b];
`ifdef MV_SERIALIZER_PARITY_EN
        if (b == DW) return ^w;
`endif
        return 1'b0;
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        clr    = 1'b0;
        valid  = 1'b0;
        sample = 1'b0;
        data   = '0;
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Sends every word in tx_q with valid held while words remain. Every
    // cycle is compared against the tick-count model. mode: 0 = sample
    // always high, k>0 = every k-th cycle, -1 = random.
    task automatic run_stream(input string tag, input int mode,
                              input int max_cycles, output int first_lat);
        bit            m_idle;
        bit            m_done;
        bit            finished;
        bit            smp;
        int            t;
        int            hs_cyc;
        int            fails_here;
        logic [DW-1:0] cur;
        logic          exp_q;
        m_idle     = 1'b1;
        m_done     = 1'b0;
        finished   = 1'b0;
        t          = 0;
        hs_cyc     = -1;
        fails_here = 0;
        cur        = '0;
        first_lat  = -1;
        q_log.delete();
        obs_hs.delete();
        obs_done.delete();
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (mode == 0)     smp = 1'b1;
            else if (mode > 0) smp = ((cyc % mode) == 0);
            else               smp = 1'($urandom_range(0, 1));
            sample = smp;
            valid  = (tx_q.size() != 0);
            data   = valid ? tx_q[0] : '0;
            @(negedge clk);
            exp_q = m_idle ? 1'b0 : line_bit(cur, t);
            n_checks++;
            if (ready !== m_idle) begin
                n_fails++; fails_here++;
                $display("FAIL %s.ready cyc %0d: got %b want %b", tag, cyc, ready, m_idle);
            end
            n_checks++;
            if (busy !== !m_idle) begin
                n_fails++; fails_here++;
                $display("FAIL %s.busy cyc %0d: got %b want %b", tag, cyc, busy, !m_idle);
            end
            n_checks++;
            if (done !== m_done) begin
                n_fails++; fails_here++;
                $display("FAIL %s.done cyc %0d: got %b want %b", tag, cyc, done, m_done);
            end
            n_checks++;
            if (q !== exp_q) begin
                n_fails++; fails_here++;
                $display("FAIL %s.q cyc %0d: got %b want %b", tag, cyc, q, exp_q);
            end
            if (hs_cyc >= 0 && first_lat < 0) q_log.push_back(q);
            if (valid && ready) obs_hs.push_back(cyc);
            if (done === 1'b1) obs_done.push_back(cyc);
            if (m_done && first_lat < 0) first_lat = cyc - hs_cyc;
            // Advance the model to the next cycle.
            m_done = 1'b0;
            if (m_idle) begin
                if (valid) begin
                    cur    = tx_q.pop_front();
                    m_idle = 1'b0;
                    t      = 0;
                    if (hs_cyc < 0) hs_cyc = cyc;
                end
            end else if (smp) begin
                t++;
                if (t == WORD_TICKS) begin
                    m_idle = 1'b1;
                    m_done = 1'b1;
                end
            end
            next_cycle();
            if (fails_here >= 8) break;
            if (m_idle && !m_done && tx_q.size() == 0) begin
                finished = 1'b1;
                break;
            end
        end
        valid  = 1'b0;
        sample = 1'b0;
        n_checks++;
        if (!finished) begin
            n_fails++;
            $display("FAIL %s.complete: stream did not complete (%0d words left, %0d errors)",
                     tag, tx_q.size(), fails_here);
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({q, busy, done} !== 3'b000) begin
            n_fails++;
            $display("FAIL reset.async: q/busy/done got %b want 000", {q, busy, done});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ready, q, busy, done} !== 4'b1000) begin
            n_fails++;
            $display("FAIL reset.release: ready/q/busy/done got %b want 1000",
                     {ready, q, busy, done});
        end
        next_cycle();
    endtask

    task automatic test_basic_a5;
        int   lat;
        logic exp_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        tx_q.delete();
        tx_q.push_back(8'hA5);
        run_stream("basic_a5", 0, 300, lat);
        n_checks++;
        if (lat !== EXP_LAT) begin
            n_fails++;
            $display("FAIL basic_a5.latency: got %0d want %0d", lat, EXP_LAT);
        end
        n_checks++;
        if (q_log.size() < WORD_TICKS) begin
            n_fails++;
            $display("FAIL basic_a5.log: got %0d entries want >= %0d", q_log.size(), WORD_TICKS);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (q_log[REP * i + 5] !== exp_seq[i]) begin
                    n_fails++;
                    $display("FAIL basic_a5.bit%0d: got %b want %b", i, q_log[REP * i + 5], exp_seq[i]);
                end
            end
`ifdef MV_SERIALIZER_PARITY_EN
            n_checks++;
            if (q_log[DW * REP + 5] !== 1'b0) begin
                n_fails++;
                $display("FAIL basic_a5.parity: got %b want 0", q_log[DW * REP + 5]);
            end
`endif
            for (int i = NBITS * REP; i < WORD_TICKS; i++) begin
                n_checks++;
                if (q_log[i] !== 1'b0) begin
                    n_fails++;
                    $display("FAIL basic_a5.gap idx %0d: got %b want 0", i, q_log[i]);
                end
            end
        end
    endtask

    task automatic test_slow_sample;
        int lat;
        int ones;
        int exp_ones;
        apply_reset();
        tx_q.delete();
        tx_q.push_back(8'h01);
        run_stream("slow_sample", 3, 1000, lat);
        ones = 0;
        foreach (q_log[i]) if (q_log[i] === 1'b1) ones++;
`ifdef MV_SERIALIZER_PARITY_EN
        exp_ones = 2 * 3 * REP;
`else
        exp_ones = 3 * REP;
`endif
        n_checks++;
        if (ones !== exp_ones) begin
            n_fails++;
            $display("FAIL slow_sample.high_cycles: got %0d want %0d", ones, exp_ones);
        end
        n_checks++;
        if (obs_done.size() !== 1) begin
            n_fails++;
            $display("FAIL slow_sample.done_count: got %0d want 1", obs_done.size());
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        apply_reset();
        tx_q.delete();
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h00);
        run_stream("back_to_back", 0, 400, lat);
        n_checks++;
        if (obs_hs.size() !== 2 || obs_done.size() !== 2) begin
            n_fails++;
            $display("FAIL b2b.counts: handshakes %0d dones %0d want 2 2",
                     obs_hs.size(), obs_done.size());
        end else begin
            n_checks++;
            if (obs_hs[1] !== obs_done[0]) begin
                n_fails++;
                $display("FAIL b2b.accept_cycle: got %0d want %0d", obs_hs[1], obs_done[0]);
            end
            n_checks++;
            if (obs_hs[1] - obs_hs[0] !== EXP_LAT) begin
                n_fails++;
                $display("FAIL b2b.spacing: got %0d want %0d", obs_hs[1] - obs_hs[0], EXP_LAT);
            end
        end
    endtask

    task automatic test_random;
        int lat;
        for (int n = 0; n < 4; n++) begin
            apply_reset();
            tx_q.delete();
            tx_q.push_back(DW'($urandom));
            run_stream("rand_single", -1, 800, lat);
        end
        apply_reset();
        tx_q.delete();
        for (int n = 0; n < 3; n++) tx_q.push_back(DW'($urandom));
        run_stream("rand_stream", -1, 2400, lat);
        n_checks++;
        if (obs_done.size() !== 3) begin
            n_fails++;
            $display("FAIL rand_stream.done_count: got %0d want 3", obs_done.size());
        end
        apply_reset();
        tx_q.delete();
        for (int n = 0; n < 2; n++) tx_q.push_back(DW'($urandom));
        run_stream("period2_stream", 2, 1200, lat);
    endtask

    task automatic test_clear;
        bit bad_done;
        bit bad_busy;
        apply_reset();
        valid  = 1'b1;
        data   = 8'hFF;
        sample = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1) begin
            n_fails++;
            $display("FAIL clear.handshake: ready got %b want 1", ready);
        end
        next_cycle();
        valid = 1'b0;
        repeat (32) next_cycle();
        // Now in bit 3 of the word.
        clr   = 1'b1;
        valid = 1'b1;
        data  = 8'h3C;
        @(negedge clk);
        n_checks++;
        if ({ready, q, busy} !== 3'b011) begin
            n_fails++;
            $display("FAIL clear.during: ready/q/busy got %b want 011", {ready, q, busy});
        end
        next_cycle();
        clr   = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ready, q, busy, done} !== 4'b1000) begin
            n_fails++;
            $display("FAIL clear.after: ready/q/busy/done got %b want 1000",
                     {ready, q, busy, done});
        end
        bad_done = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            next_cycle();
            @(negedge clk);
            if (done !== 1'b0) bad_done = 1'b1;
            if (busy !== 1'b0 || q !== 1'b0) bad_busy = 1'b1;
        end
        next_cycle();
        n_checks++;
        if (bad_done) begin
            n_fails++;
            $display("FAIL clear.no_done: done_o got 1 want 0");
        end
        n_checks++;
        if (bad_busy) begin
            n_fails++;
            $display("FAIL clear.idle: busy/q got activity want idle");
        end
        sample = 1'b0;
    endtask

    task automatic test_async_reset;
        bit bad_done;
        apply_reset();
        valid  = 1'b1;
        data   = 8'hA5;
        sample = 1'b1;
        next_cycle();
        valid = 1'b0;
        repeat (NBITS * REP + 1) next_cycle();
        @(negedge clk);
        n_checks++;
        if ({busy, q, done} !== 3'b100) begin
            n_fails++;
            $display("FAIL async_rst.mid_gap: busy/q/done got %b want 100", {busy, q, done});
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({q, busy, done} !== 3'b000) begin
            n_fails++;
            $display("FAIL async_rst.immediate: q/busy/done got %b want 000", {q, busy, done});
        end
        next_cycle();
        rst      = 1'b0;
        bad_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad_done = 1'b1;
            next_cycle();
        end
        n_checks++;
        if (bad_done) begin
            n_fails++;
            $display("FAIL async_rst.no_done: done/busy active after reset");
        end
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1) begin
            n_fails++;
            $display("FAIL async_rst.ready: got %b want 1", ready);
        end
        next_cycle();
        sample = 1'b0;
    endtask

`ifdef MV_SERIALIZER_PARITY_EN
    task automatic test_parity;
        int lat;
        int highs;
        apply_reset();
        tx_q.delete();
        tx_q.push_back(8'h07);
        run_stream("parity_07", 0, 300, lat);
        highs = 0;
        for (int i = DW * REP; i < DW * REP + REP && i < q_log.size(); i++)
            if (q_log[i] === 1'b1) highs++;
        n_checks++;
        if (highs !== REP) begin
            n_fails++;
            $display("FAIL parity_07.held: got %0d high cycles want %0d", highs, REP);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_a5();
        test_slow_sample();
        test_back_to_back();
        test_random();
        test_clear();
        test_async_reset();
`ifdef MV_SERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mv_serializer.md
MV_SERIALIZER -- requirements
Module: mv_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per transmitted word; legal range >=1.
REQ-002 SHALL have parameter REPEAT, default 10: sample ticks each bit is held on the line; legal range >=1; elaboration assertion otherwise.
REQ-003 SHALL have parameter GAP, default 4: sample ticks of forced-low line after each word; legal range >=1.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_i, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port clr_i, input, 1: synchronous clear, same effect as reset.
REQ-007 SHALL have port sample_i, input, 1: tick strobe advancing the hold counter.
REQ-008 SHALL have port valid_i, input, 1: word offered.
REQ-009 SHALL have port ready_o, output, 1: word accepted when valid_i && ready_o.
REQ-010 SHALL have port data_i, input, DATA_WIDTH: word to send.
REQ-011 SHALL have port q_o, output, 1: serial line, registered.
REQ-012 SHALL have port busy_o, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port done_o, output, 1: single-cycle pulse on word completion.

Function
REQ-014 SHALL implement FSM states IDLE, DATA, [PARITY], GAP.
REQ-015 ready_o SHALL equal (state==IDLE) && !clr_i; no combinational path from valid_i to ready_o.
REQ-016 On handshake SHALL load data_i into a shift register, clear tick counter and bit index, enter DATA.
REQ-017 In DATA, q_o SHALL present shift-register bit 0 (LSB first), starting the cycle after handshake (1-cycle latency).
REQ-018 Tick counter SHALL be $clog2(REPEAT+1) bits wide and SHALL increment only on cycles with sample_i=1.
REQ-019 When a tick brings the counter to REPEAT, SHALL in the same edge clear the counter, shift right, increment bit index; no wrap past REPEAT.
REQ-020 After bit DATA_WIDTH-1 completes, SHALL enter PARITY if compiled in, else GAP.
REQ-021 In GAP, q_o SHALL be 0; after GAP ticks SHALL enter IDLE and assert done_o for exactly that one cycle.
REQ-022 In IDLE q_o SHALL be 0; sample_i SHALL be ignored.
REQ-023 sample_i held high continuously SHALL yield exactly REPEAT clock cycles per bit.
REQ-024 A new handshake SHALL be possible in the first IDLE cycle (cycle done_o is high); back-to-back words separated only by GAP.
REQ-025 clr_i SHALL dominate all events: abort to IDLE, q_o=0, counter/index cleared, no done_o, simultaneous valid_i not accepted.

Reset
REQ-026 On rst_i SHALL immediately set state IDLE, q_o=0, busy_o=0, done_o=0, ready_o=1 once released, counters and shift register 0.
REQ-027 Reset mid-word SHALL discard the word without done_o.

Configuration
REQ-028 With macro MV_SERIALIZER_PARITY_EN defined, SHALL append PARITY state holding even parity (XOR of the word) for REPEAT ticks before GAP.
REQ-029 Without MV_SERIALIZER_PARITY_EN, PARITY state and logic SHALL not exist; DATA proceeds directly to GAP.

Verification
REQ-030 DATA_WIDTH=8, REPEAT=10, GAP=4, sample_i=1, send 0xA5 -> q_o 1,0,1,0,0,1,0,1 each 10 cycles, 4 low cycles, done_o at cycle 85 after handshake (95 with parity, parity bit 0).
REQ-031 sample_i every 3rd cycle, send 0x01 -> bit 0 high for 30 cycles, remaining bits low, done_o once.
REQ-032 Two words 0xFF then 0x00 with valid_i held -> second accepted in done_o cycle; q_o low exactly 4 ticks between words.
REQ-033 clr_i asserted at bit 3 together with valid_i -> q_o=0 next cycle, no done_o, ready_o=1 cycle after, valid_i not consumed.
REQ-034 rst_i asynchronously asserted mid-GAP -> all outputs reset before next clock edge; no done_o.
REQ-035 Parity build, send 0x07 -> parity bit 1 held 10 ticks before GAP.
